ss_adc_frame_rx: RTL and testbench
==================================

// Module: ss_adc_frame_rx
// PURPOSE
//  Receive end of the single-slope ADC nibble stream. Runs a counter in lockstep with the ADC counter and
//  rebuilds the 128 x 8-bit column codes from the 4-bit serial output, low nibble first. Codes leave through a
//  valid/ready stream with channel index and frame markers, buffered in a small FIFO. Sits between the ADC
//  counter and the readout/AXI packer on the Z7 fabric.
// PARAMETERS
//  NUM_CH      128  columns per frame
//  CODE_W      8    bits per code
//  NIB_W       4    serial nibble width; NIB_PER_CODE = CODE_W/NIB_W = 2
//  REST_CYC    7    dead cycles per frame (counter 256..262)
//  FIFO_DEPTH  8    output FIFO entries, power of 2
// PORTS
//  clk          in   1   system clock, same clock as the ADC counter
//  n_reset      in   1   asynchronous active-low reset
//  enable       in   1   the same enable that drives the ADC counter
//  adc_nibble   in   4   ADC serial nibble output
//  code_data    out  8   code at FIFO head
//  code_ch      out  7   column index of code_data
//  code_sof     out  1   head entry is channel 0 of a frame
//  code_eof     out  1   head entry is channel NUM_CH-1
//  code_valid   out  1   FIFO not empty
//  code_ready   in   1   consumer accepts head when code_valid & code_ready
//  frame_count  out  16  completed frames (eof pushed), wraps 0xFFFF->0
//  overflow     out  1   sticky: a code was dropped because the FIFO was full
//  sat_count    out  8   only with SS_ADC_SAT_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rx_cnt=255, low-nibble reg=0, FIFO empty.
//    Outputs at reset: code_valid=0, code_data/ch/sof/eof=0, frame_count=0, overflow=0, sat_count=0.
//  - rx_cnt (9 bit) mirrors the ADC counter.
//    enable=0: rx_cnt<=255, partial byte discarded.
//    enable=1: 262->0; otherwise +1. This gives 255->256, the rest cycles 256..262, then 0.
//  - Sample at posedge, only when enable=1 and rx_cnt<=255.
//    rx_cnt even: store adc_nibble as the low nibble.
//    rx_cnt odd: push {data={adc_nibble,low}, ch=rx_cnt[7:1], sof=(ch==0), eof=(ch==127)}.
//    Rest cycles 256..262: no sampling.
//  - Frame = 263 cycles, 128 pushes, one push every 2 cycles.
//  - Latency: the push on the odd-count edge appears on code_valid in the next cycle.
//  - FIFO is first-word fall-through: code_* are driven from the head register.
//  - Full + push with no pop: drop the entry, set overflow. If the dropped entry had eof, frame_count does not
//    increment.
//  - Full + push + pop in the same cycle: the push is accepted.
//  - Empty: a push with code_ready high is still seen one cycle later. No bypass.
//  - overflow is cleared only by reset or by a falling edge of enable.
//  - enable drops mid-frame: frame is aborted. No eof is generated. Queued entries still drain. The next frame
//    starts at rx_cnt=0 after 255, 256..262.
//  - The first 0..255 pass after enable rises carries the code buffer the ADC captured on its previous frame.
//    The receiver forwards it unchanged; discarding it is the consumer's job.
// CONFIGURATION
//  SS_ADC_SAT_COUNT_EN defined:
//    - Count pushed codes equal to 8'hFF, i.e. columns that never converted in the frame.
//    - On the eof push, load sat_count with the total including that entry. The accumulator clears at rx_cnt=0.
//    - sat_count holds until the next eof.
//  Not defined: sat_count port absent, no counter logic.
// STRUCTURE
//  - Package ss_adc_pkg holds: NUM_CH, CODE_W, NIB_W, FRAME_LAST=262, DATA_LAST=255, SAT_CODE=8'hFF, and the
//    FIFO entry layout {sof, eof, ch[6:0], data[7:0]} (17 bits). The ADC counter shares this package.
//  - One sub-module, ss_adc_rx_fifo: synchronous FWFT FIFO with push, pop, full, empty, a 17-bit entry, and the
//    simultaneous full push+pop rule.
// TESTING
//  1. Nibble model of ADC buffer with ch k = k, code_ready=1
//     -> 128 codes with ch=data=0..127.
//     -> sof on ch0, eof on ch127; frame_count 0->1 after 263 cycles.
//  2. Nibble pair 0xA (rx_cnt=10), 0x5 (rx_cnt=11)
//     -> code_data=8'h5A, code_ch=5, code_valid rises at the cycle after rx_cnt=11.
//  3. code_ready=0 for 20 cycles from frame start
//     -> 8 codes held; 9th (ch8) and 10th (ch9) dropped; overflow=1; ch10 onward accepted once drained.
//  4. enable low at rx_cnt=100, high 5 cycles later
//     -> no eof; frame_count unchanged; next frame starts at ch0 after 8 idle cycles.
//  5. FIFO full, pop and push in the same cycle
//     -> entry accepted, overflow stays 0.
//  6. SS_ADC_SAT_COUNT_EN, codes ch0..9 = 8'hFF, rest 8'h10
//     -> sat_count=10 after eof; next frame all 8'h10 -> sat_count=0.

Source files
------------

// File: rtl/ss_adc_pkg.sv
// Shared constants and FIFO entry layout for the single-slope ADC counter
// and its nibble-stream receiver.
package ss_adc_pkg;

  localparam int NUM_CH       = 128;
  localparam int CODE_W       = 8;
  localparam int NIB_W        = 4;
  localparam int NIB_PER_CODE = CODE_W / NIB_W;
  localparam int CH_W         = 7;
  localparam int CNT_W        = 9;
  localparam int FIFO_DEPTH   = 8;

  localparam logic [CNT_W-1:0]  FRAME_LAST = 9'd262;
  localparam logic [CNT_W-1:0]  DATA_LAST  = 9'd255;
  localparam logic [CODE_W-1:0] SAT_CODE   = 8'hFF;

  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [CH_W-1:0]   ch;
    logic [CODE_W-1:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/ss_adc_rx_fifo.sv
// First-word-fall-through FIFO for received column codes.
// A push into a full FIFO is still accepted when the head is popped in the
// same cycle; o_accept tells the caller whether the pushed entry was kept.
module ss_adc_rx_fifo
  import ss_adc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      n_reset,
  input  logic      i_push,
  input  rx_entry_t i_entry,
  input  logic      i_pop,
  output rx_entry_t o_head,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_accept
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_accept;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_pop    = i_pop & ~o_empty;
  assign w_accept = i_push & (~o_full | w_pop);
  assign o_accept = w_accept;
  assign o_head   = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; storage is reset so the head reads zero.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ss_adc_frame_rx.sv
// Receive end of the single-slope ADC nibble stream. Tracks the ADC counter,
// rebuilds 8-bit column codes from low/high nibble pairs and queues them in
// an FWFT FIFO with channel index and frame markers.
// Optional: define SS_ADC_SAT_COUNT_EN to add the per-frame saturated-code
// counter and its sat_count output.
module ss_adc_frame_rx
  import ss_adc_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic [NIB_W-1:0]  adc_nibble,
  output logic [CODE_W-1:0] code_data,
  output logic [CH_W-1:0]   code_ch,
  output logic              code_sof,
  output logic              code_eof,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [15:0]       frame_count,
  output logic              overflow
`ifdef SS_ADC_SAT_COUNT_EN
  ,
  output logic [7:0]        sat_count
`endif
);

  logic [CNT_W-1:0] r_rx_cnt;
  logic [NIB_W-1:0] r_low;
  logic             r_in_frame;
  logic             r_en_d;
  logic [15:0]      r_frame_count;
  logic             r_overflow;

  logic             w_sample;
  logic             w_push;
  logic             w_accept;
  logic [CH_W-1:0]  w_ch;
  rx_entry_t        w_entry;
  rx_entry_t        w_head;
  logic             w_full;
  logic             w_empty;

  // The 255 reached after enable rises is the counter's parking value, not
  // the last data slot of a frame; sampling starts only once the counter has
  // wrapped 262->0, which r_in_frame records.
  assign w_sample = enable & r_in_frame & (r_rx_cnt <= DATA_LAST);
  assign w_push   = w_sample & r_rx_cnt[0];
  assign w_ch     = r_rx_cnt[7:1];

  assign w_entry.sof  = (w_ch == '0);
  assign w_entry.eof  = (w_ch == CH_W'(NUM_CH-1));
  assign w_entry.ch   = w_ch;
  assign w_entry.data = {adc_nibble, r_low};

  // Frame counter mirroring the ADC counter: parked at 255 while disabled.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rx_cnt   <= DATA_LAST;
      r_in_frame <= 1'b0;
    end else if (!enable) begin
      r_rx_cnt   <= DATA_LAST;
      r_in_frame <= 1'b0;
    end else if (r_rx_cnt == FRAME_LAST) begin
      r_rx_cnt   <= '0;
      r_in_frame <= 1'b1;
    end else begin
      r_rx_cnt   <= r_rx_cnt + 1'b1;
    end
  end

  // Low nibble capture on even counts; a disable discards a partial byte.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                    r_low <= '0;
    else if (!enable)                r_low <= '0;
    else if (w_sample & ~r_rx_cnt[0]) r_low <= adc_nibble;
  end

  ss_adc_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .i_push   (w_push),
    .i_entry  (w_entry),
    .i_pop    (code_ready),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_accept (w_accept)
  );

  // Completed frames count only when the eof entry actually made it in;
  // overflow is sticky until a falling edge of enable.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_en_d        <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (w_accept & w_entry.eof) r_frame_count <= r_frame_count + 1'b1;
      if (r_en_d & ~enable)       r_overflow <= 1'b0;
      else if (w_push & ~w_accept) r_overflow <= 1'b1;
    end
  end

`ifdef SS_ADC_SAT_COUNT_EN
  logic [7:0] r_sat_acc;
  logic [7:0] r_sat_count;
  logic       w_is_sat;

  assign w_is_sat  = w_push & (w_entry.data == SAT_CODE);
  assign sat_count = r_sat_count;

  // Saturated-code tally per frame, published on the eof push.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sat_acc   <= '0;
      r_sat_count <= '0;
    end else begin
      if (enable && (r_rx_cnt == '0)) r_sat_acc <= '0;
      else if (w_is_sat)              r_sat_acc <= r_sat_acc + 1'b1;
      if (w_push & w_entry.eof) r_sat_count <= r_sat_acc + {7'd0, w_is_sat};
    end
  end
`endif

  assign code_data   = w_head.data;
  assign code_ch     = w_head.ch;
  assign code_sof    = w_head.sof;
  assign code_eof    = w_head.eof;
  assign code_valid  = ~w_empty;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ss_adc_frame_rx.sv
// Bench for ss_adc_frame_rx: drives a modelled ADC code buffer as nibbles and
// compares the output stream against an 8-entry queue model.
module tb_ss_adc_frame_rx;

  logic        clk;
  logic        n_reset;
  logic        enable;
  logic [3:0]  adc_nibble;
  logic [7:0]  code_data;
  logic [6:0]  code_ch;
  logic        code_sof;
  logic        code_eof;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] frame_count;
  logic        overflow;
`ifdef SS_ADC_SAT_COUNT_EN
  logic [7:0]  sat_count;
`endif

  ss_adc_frame_rx dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .enable      (enable),
    .adc_nibble  (adc_nibble),
    .code_data   (code_data),
    .code_ch     (code_ch),
    .code_sof    (code_sof),
    .code_eof    (code_eof),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .frame_count (frame_count),
    .overflow    (overflow)
`ifdef SS_ADC_SAT_COUNT_EN
    ,
    .sat_count   (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [16:0] q[$];
  logic [7:0]  cur[128];
  int          mode;
  int          m_k;        // edges since enable rose (0 while disabled)
  bit          prev_en;
  logic [15:0] exp_fc;
  logic        exp_ovf;
  logic [7:0]  exp_sat;
  logic [15:0] saved_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_codes();
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0:       cur[i] = 8'(i);
        2:       cur[i] = (i < 10) ? 8'hFF : 8'h10;
        3:       cur[i] = 8'h10;
        default: cur[i] = 8'($urandom_range(0, 255));
      endcase
    end
    if (mode == 4) cur[5] = 8'h5A;
  endtask

  function automatic logic [7:0] count_sat();
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 128; i++) if (cur[i] == 8'hFF) n++;
    return n;
  endfunction

  task automatic check_outputs();
    logic [16:0] head;
    chk("code_valid", 32'(code_valid), 32'(q.size() != 0));
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (q.size() != 0) begin
      head = q[0];
      chk("code_sof", 32'(code_sof), 32'(head[16]));
      chk("code_eof", 32'(code_eof), 32'(head[15]));
      chk("code_ch", 32'(code_ch), 32'(head[14:8]));
      chk("code_data", 32'(code_data), 32'(head[7:0]));
    end
`ifdef SS_ADC_SAT_COUNT_EN
    chk("sat_count", 32'(sat_count), 32'(exp_sat));
`endif
  endtask

  // One clock: drive at negedge, advance model across the posedge, compare.
  task automatic run_cycle(input bit en, input bit rdy);
    int          p;
    int          sz;
    bit          push;
    bit          pop;
    logic [6:0]  ch;
    logic [3:0]  nib;
    @(negedge clk);
    push = 1'b0;
    ch   = '0;
    nib  = 4'($urandom_range(0, 15));
    if (en && m_k >= 8) begin
      p = (m_k - 8) % 263;
      if (p == 0) fill_codes();
      if (p <= 255) begin
        ch   = 7'(p / 2);
        nib  = (p % 2 == 1) ? cur[ch][7:4] : cur[ch][3:0];
        push = (p % 2 == 1);
      end
    end
    enable     = en;
    code_ready = rdy;
    adc_nibble = nib;
    sz  = q.size();
    pop = rdy && (sz != 0);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < 8 || pop) begin
        q.push_back({ch == 7'd0, ch == 7'd127, ch, cur[ch]});
        if (ch == 7'd127) exp_fc++;
      end else begin
        exp_ovf = 1'b1;
      end
      if (ch == 7'd127) exp_sat = count_sat();
    end
    if (prev_en && !en) exp_ovf = 1'b0;
    prev_en = en;
    m_k = en ? m_k + 1 : 0;
    check_outputs();
  endtask

  initial begin
    enable     = 1'b0;
    code_ready = 1'b0;
    adc_nibble = 4'h0;
    n_reset    = 1'b0;
    mode       = 0;
    m_k        = 0;
    prev_en    = 1'b0;
    exp_fc     = '0;
    exp_ovf    = 1'b0;
    exp_sat    = '0;
    #12;
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_data", 32'(code_data), 32'd0);
    chk("rst_ch", 32'(code_ch), 32'd0);
    chk("rst_sof", 32'(code_sof), 32'd0);
    chk("rst_eof", 32'(code_eof), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef SS_ADC_SAT_COUNT_EN
    chk("rst_sat", 32'(sat_count), 32'd0);
`endif
    @(negedge clk);
    n_reset = 1'b1;

    // Ramp frame: ch k carries code k; frame_count steps on the eof push.
    mode = 0;
    repeat (263) run_cycle(1'b1, 1'b1);
    chk("t1_fc_before_eof", 32'(frame_count), 32'd0);
    run_cycle(1'b1, 1'b1);
    chk("t1_fc_after_eof", 32'(frame_count), 32'd1);
    repeat (7) run_cycle(1'b1, 1'b1);

    // Nibble pair 0xA / 0x5 at counts 10 / 11 -> 0x5A on ch5 one cycle later.
    mode = 4;
    repeat (11) run_cycle(1'b1, 1'b1);
    chk("t2_valid_pre", 32'(code_valid), 32'd0);
    run_cycle(1'b1, 1'b1);
    chk("t2_valid", 32'(code_valid), 32'd1);
    chk("t2_data", 32'(code_data), 32'h5A);
    chk("t2_ch", 32'(code_ch), 32'd5);
    repeat (251) run_cycle(1'b1, 1'b1);

    // Consumer stalls 20 cycles from frame start: ch8, ch9 dropped.
    mode = 1;
    repeat (20) run_cycle(1'b1, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_head_ch", 32'(code_ch), 32'd0);
    repeat (243) run_cycle(1'b1, 1'b1);

    // Abort mid-frame: no eof, overflow cleared by the enable fall.
    mode = 1;
    repeat (100) run_cycle(1'b1, 1'b1);
    saved_fc = exp_fc;
    repeat (5) run_cycle(1'b0, 1'b1);
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    chk("t4_fc_held", 32'(frame_count), 32'(saved_fc));
    repeat (8) run_cycle(1'b1, 1'b1);
    chk("t4_idle_empty", 32'(code_valid), 32'd0);

    // Full FIFO with pop and push in the same cycle.
    mode = 1;
    repeat (17) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    chk("t5_ovf_same_cycle", 32'(overflow), 32'd0);
    repeat (245) run_cycle(1'b1, 1'b1);
    chk("t5_ovf_end", 32'(overflow), 32'd0);

    // Random codes with a randomly stalling consumer.
    repeat (2) begin
      mode = 1;
      repeat (263) run_cycle(1'b1, 1'($urandom_range(0, 1)));
    end

`ifdef SS_ADC_SAT_COUNT_EN
    mode = 2;
    repeat (263) run_cycle(1'b1, 1'b1);
    chk("t6_sat10", 32'(sat_count), 32'd10);
    mode = 3;
    repeat (263) run_cycle(1'b1, 1'b1);
    chk("t6_sat0", 32'(sat_count), 32'd0);
`endif

    repeat (20) run_cycle(1'b0, 1'b1);
    chk("drain_empty", 32'(code_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
